// File: rtl/mac_pkg.sv
// mac_pkg: frame layout constants, FSM state codes and the CRC-32 byte step shared by the TX path.
package mac_pkg;
  localparam logic [7:0] IDLE_CODE = 8'h07;
  localparam logic [7:0] START_CODE = 8'hFB;
  localparam logic [7:0] TERM_CODE = 8'hFD;
  localparam logic [7:0] PREAMBLE_CODE = 8'h55;
  localparam logic [7:0] SFD_CODE = 8'hD5;
  localparam logic [47:0] DST_ADDR_CODE = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SRC_ADDR_CODE = 48'h123456789ABC;
  localparam int PREAMBLE_SIZE = 6;
  localparam int DA_SIZE = 6;
  localparam int SA_SIZE = 6;
  localparam int LENGTH_TYPE = 2;
  localparam int FCS_SIZE = 4;
  localparam int MIN_MAC_CLIENT_DATA = 46;
  localparam int MAX_MAC_CLIENT_DATA = 1500;
  // absolute byte offsets, counting the START character as byte 0
  localparam int DA_START = 2 + PREAMBLE_SIZE;
  localparam int SA_START = DA_START + DA_SIZE;
  localparam int LEN_START = SA_START + SA_SIZE;
  localparam int PAY_START = LEN_START + LENGTH_TYPE;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;
  localparam logic [1:0] ST_TERM = 2'd3;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC_POLY : c >> 1;
    return c;
  endfunction
endpackage

// File: rtl/mac_tx_crc64.sv
// mac_tx_crc64: one-cycle CRC-32 step over up to eight byte lanes, lane 0 first.
module mac_tx_crc64
  import mac_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  input  logic [7:0]  lane_en,
  output logic [31:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int l = 0; l < 8; l++) crc_out = lane_en[l] ? crc32_byte(crc_out, data[8*l+:8]) : crc_out;
  end
endmodule

// File: rtl/mac_frame_generator.sv
// mac_frame_generator: builds one Ethernet frame per request on a 64-bit data/ctrl bus.
module mac_frame_generator
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [10:0]           i_payload_len,
  input  logic [7:0]            i_seed,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
  output logic                  o_frame_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_len_err
);
  logic [1:0] state;
  logic [7:0] wcnt, w, seed_q, crc_en, gen_ctrl;
  logic [10:0] len_q, p, t;
  logic [31:0] crc_q, crc_next;
  logic [63:0] data_w, gen_data;
  logic req, last;
  // w is the index of the word being built; the word on the bus is wcnt
  assign w = wcnt + 8'd1;
  assign p = len_q < 11'(MIN_MAC_CLIENT_DATA) ? 11'(MIN_MAC_CLIENT_DATA) : len_q;
  assign t = p + 11'(PAY_START + FCS_SIZE);
  assign last = w == t[10:3];
  assign req = i_start && !o_busy;
  for (genvar l = 0; l < 8; l++) begin : g_lane
    logic [10:0] b, k;
    logic [1:0] f;
    assign b = {w, 3'(l)};
    assign k = b - 11'(PAY_START);
    assign f = 2'(k - p);
    assign data_w[8*l+:8] = b < 11'(SA_START) ? 8'(DST_ADDR_CODE >> {b - 11'(DA_START), 3'b0})
                          : b < 11'(LEN_START) ? 8'(SRC_ADDR_CODE >> {b - 11'(SA_START), 3'b0})
                          : b < 11'(PAY_START) ? (b[0] ? {5'd0, len_q[10:8]} : len_q[7:0])
                          : k < len_q ? seed_q + k[7:0] : 8'h00;
    assign crc_en[l] = b < p + 11'(PAY_START);
    // FCS lanes read the running CRC; once all data lanes are past it equals the registered value
    assign gen_data[8*l+:8] = crc_en[l] ? data_w[8*l+:8]
                            : b < t ? 8'(~crc_next >> {f, 3'b0})
                            : b == t ? TERM_CODE : IDLE_CODE;
    assign gen_ctrl[l] = b >= t;
  end
  mac_tx_crc64 u_crc (
    .crc_in(crc_q),
    .data(data_w),
    .lane_en(crc_en),
    .crc_out(crc_next)
  );
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      wcnt <= '0;
      len_q <= '0;
      seed_q <= '0;
      crc_q <= '1;
      o_tx_data <= {8{IDLE_CODE}};
      o_tx_ctrl <= '1;
      o_frame_valid <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_len_err <= 1'b0;
    end else if (state == ST_IDLE) begin
      o_done <= 1'b0;
      o_len_err <= req && i_payload_len > 11'(MAX_MAC_CLIENT_DATA);
      if (req && i_payload_len <= 11'(MAX_MAC_CLIENT_DATA)) begin
        state <= ST_PRE;
        wcnt <= '0;
        len_q <= i_payload_len;
        seed_q <= i_seed;
        crc_q <= '1;
        o_tx_data <= {SFD_CODE, {PREAMBLE_SIZE{PREAMBLE_CODE}}, START_CODE};
        o_tx_ctrl <= 8'h01;
        o_frame_valid <= 1'b1;
        o_busy <= 1'b1;
      end else begin
        o_tx_data <= {8{IDLE_CODE}};
        o_tx_ctrl <= '1;
        o_frame_valid <= 1'b0;
        o_busy <= 1'b0;
      end
    end else begin
      state <= last ? ST_IDLE : (w + 8'd1 == t[10:3] && t[2:0] == 3'd0) ? ST_TERM : ST_BODY;
      wcnt <= w;
      crc_q <= crc_next;
      o_tx_data <= gen_data;
      o_tx_ctrl <= gen_ctrl;
      o_frame_valid <= 1'b1;
      o_busy <= 1'b1;
      o_done <= last;
      o_len_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mac_frame_generator.sv
// tb_mac_frame_generator: directed frame checks against hand values and a byte-stream reference.
module tb_mac_frame_generator;
  logic clk = 1'b0;
  logic i_rst_n, i_start;
  logic [10:0] i_payload_len;
  logic [7:0] i_seed;
  logic [63:0] o_tx_data;
  logic [7:0] o_tx_ctrl;
  logic o_frame_valid, o_busy, o_done, o_len_err;
  int n_assert = 0;
  int n_fail = 0;
  logic [63:0] cap_d [0:255];
  logic [7:0] cap_c [0:255];
  logic [2:0] cap_s [0:255];
  int nw;
  bit timeout;
  logic [7:0] eb [0:1535];
  logic ek [0:1535];
  int m_words, m_t;
  localparam logic [63:0] IDLE_W = 64'h0707070707070707;

  mac_frame_generator dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_payload_len(i_payload_len),
    .i_seed(i_seed), .o_tx_data(o_tx_data), .o_tx_ctrl(o_tx_ctrl), .o_frame_valid(o_frame_valid),
    .o_busy(o_busy), .o_done(o_done), .o_len_err(o_len_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    c = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return c;
  endfunction

  task automatic build_model(input int len, input int seed);
    int p;
    logic [31:0] crc;
    logic [47:0] sa;
    sa = 48'h123456789ABC;
    p = len < 46 ? 46 : len;
    m_t = 26 + p;
    for (int i = 0; i < 1536; i++) begin
      eb[i] = 8'h07;
      ek[i] = 1'b1;
    end
    eb[0] = 8'hFB;
    for (int i = 1; i < m_t; i++) ek[i] = 1'b0;
    for (int i = 1; i < 7; i++) eb[i] = 8'h55;
    eb[7] = 8'hD5;
    for (int i = 0; i < 6; i++) begin
      eb[8+i] = 8'hFF;
      eb[14+i] = sa[8*i+:8];
    end
    eb[20] = 8'(len);
    eb[21] = 8'(len >> 8);
    for (int k = 0; k < p; k++) eb[22+k] = k < len ? 8'(seed + k) : 8'h00;
    crc = 32'hFFFFFFFF;
    for (int i = 8; i < 22 + p; i++) crc = crc_upd(crc, eb[i]);
    crc = ~crc;
    for (int i = 0; i < 4; i++) eb[22+p+i] = crc[8*i+:8];
    eb[m_t] = 8'hFD;
    m_words = m_t / 8 + 1;
  endtask

  function automatic logic [63:0] exp_d(input int w);
    logic [63:0] r;
    for (int l = 0; l < 8; l++) r[8*l+:8] = eb[8*w+l];
    return r;
  endfunction

  function automatic logic [7:0] exp_c(input int w);
    logic [7:0] r;
    for (int l = 0; l < 8; l++) r[l] = ek[8*w+l];
    return r;
  endfunction

  task automatic send(input int len, input int seed, input bit hold);
    i_payload_len = 11'(len);
    i_seed = 8'(seed);
    i_start = 1'b1;
    @(negedge clk);
    if (!hold) i_start = 1'b0;
    nw = 0;
    timeout = 1'b0;
    while (1) begin
      cap_d[nw] = o_tx_data;
      cap_c[nw] = o_tx_ctrl;
      cap_s[nw] = {o_frame_valid, o_busy, o_done};
      nw++;
      if (o_done) break;
      if (nw == 256) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_payload_len = '0;
    i_seed = '0;
    repeat (3) @(negedge clk);
    n_assert++;
    if (o_tx_data !== IDLE_W || o_tx_ctrl !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_bus: got %h/%h expected %h/ff", o_tx_data, o_tx_ctrl, IDLE_W);
    end
    n_assert++;
    if ({o_frame_valid, o_busy, o_done, o_len_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {o_frame_valid, o_busy, o_done, o_len_err});
    end
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame(input int len, input int seed, input int words, input logic [7:0] last_ctrl);
    logic [31:0] res;
    build_model(len, seed);
    send(len, seed, 1'b0);
    n_assert++;
    if (timeout) begin
      n_fail++;
      $display("FAIL frame_timeout len=%0d: no o_done within 256 words", len);
    end
    n_assert++;
    if (nw !== words) begin
      n_fail++;
      $display("FAIL word_count len=%0d: got %0d expected %0d", len, nw, words);
    end
    n_assert++;
    if (cap_d[0] !== 64'hD5555555555555FB || cap_c[0] !== 8'h01) begin
      n_fail++;
      $display("FAIL start_word len=%0d: got %h/%h expected d5555555555555fb/01", len, cap_d[0], cap_c[0]);
    end
    for (int w = 0; w < nw && w < m_words; w++) begin
      n_assert++;
      if (cap_d[w] !== exp_d(w) || cap_c[w] !== exp_c(w) || cap_s[w] !== {2'b11, w == m_words - 1}) begin
        n_fail++;
        $display("FAIL frame_word len=%0d w=%0d: got %h/%h/%b expected %h/%h/%b", len, w, cap_d[w], cap_c[w],
                 cap_s[w], exp_d(w), exp_c(w), {2'b11, w == m_words - 1});
      end
    end
    n_assert++;
    if (cap_c[nw-1] !== last_ctrl) begin
      n_fail++;
      $display("FAIL term_ctrl len=%0d: got %h expected %h", len, cap_c[nw-1], last_ctrl);
    end
    res = 32'hFFFFFFFF;
    for (int b = 8; b < m_t && (b >> 3) < nw; b++) res = crc_upd(res, cap_d[b>>3][(b&7)*8+:8]);
    n_assert++;
    if (res !== 32'hDEBB20E3) begin
      n_fail++;
      $display("FAIL fcs_residue len=%0d: got %h expected debb20e3", len, res);
    end
    @(negedge clk);
    n_assert++;
    if (o_busy !== 1'b0 || o_frame_valid !== 1'b0 || o_tx_data !== IDLE_W || o_tx_ctrl !== 8'hFF) begin
      n_fail++;
      $display("FAIL post_idle len=%0d: got busy=%b fv=%b %h/%h expected 0 0 %h/ff", len, o_busy,
               o_frame_valid, o_tx_data, o_tx_ctrl, IDLE_W);
    end
  endtask

  task automatic test_short_payload;
    test_frame(10, 8'h33, 10, 8'hFF);
    n_assert++;
    if (cap_d[2][63:32] !== 32'h3433000A) begin
      n_fail++;
      $display("FAIL len_field: got %h expected 3433000a", cap_d[2][63:32]);
    end
    n_assert++;
    if (cap_d[3][63:56] !== 8'h3C || cap_d[4][7:0] !== 8'h00) begin
      n_fail++;
      $display("FAIL pad_start: got %h,%h expected 3c,00", cap_d[3][63:56], cap_d[4][7:0]);
    end
  endtask

  task automatic test_pattern;
    test_frame(50, 8'hA0, 10, 8'hF0);
    n_assert++;
    if (cap_d[2][63:48] !== 16'hA1A0 || cap_d[8][63:56] !== 8'hD1) begin
      n_fail++;
      $display("FAIL pattern_ends: got %h,%h expected a1a0,d1", cap_d[2][63:48], cap_d[8][63:56]);
    end
  endtask

  task automatic test_len_err;
    i_payload_len = 11'd1501;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n_assert++;
    if (o_len_err !== 1'b1 || o_busy !== 1'b0 || o_frame_valid !== 1'b0 || o_tx_data !== IDLE_W) begin
      n_fail++;
      $display("FAIL len_err_pulse: got err=%b busy=%b fv=%b %h expected 1 0 0 %h", o_len_err, o_busy,
               o_frame_valid, o_tx_data, IDLE_W);
    end
    @(negedge clk);
    n_assert++;
    if (o_len_err !== 1'b0 || o_tx_data !== IDLE_W || o_tx_ctrl !== 8'hFF) begin
      n_fail++;
      $display("FAIL len_err_after: got err=%b %h/%h expected 0 %h/ff", o_len_err, o_tx_data, o_tx_ctrl, IDLE_W);
    end
  endtask

  task automatic test_back_to_back;
    int cnt;
    build_model(46, 0);
    send(46, 0, 1'b1);
    n_assert++;
    if (nw !== 10) begin
      n_fail++;
      $display("FAIL b2b_first_words: got %0d expected 10", nw);
    end
    @(negedge clk);
    n_assert++;
    if (o_busy !== 1'b0 || o_frame_valid !== 1'b0 || o_tx_data !== IDLE_W) begin
      n_fail++;
      $display("FAIL b2b_gap: got busy=%b fv=%b %h expected 0 0 %h", o_busy, o_frame_valid, o_tx_data, IDLE_W);
    end
    @(negedge clk);
    i_start = 1'b0;
    n_assert++;
    if (o_tx_data !== 64'hD5555555555555FB || o_tx_ctrl !== 8'h01 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_restart: got %h/%h busy=%b expected d5555555555555fb/01 1", o_tx_data, o_tx_ctrl, o_busy);
    end
    cnt = 1;
    while (cnt < 20 && !o_done) begin
      @(negedge clk);
      n_assert++;
      if (o_tx_data !== exp_d(cnt) || o_tx_ctrl !== exp_c(cnt)) begin
        n_fail++;
        $display("FAIL b2b_word w=%0d: got %h/%h expected %h/%h", cnt, o_tx_data, o_tx_ctrl, exp_d(cnt), exp_c(cnt));
      end
      cnt++;
    end
    n_assert++;
    if (cnt !== 10) begin
      n_fail++;
      $display("FAIL b2b_second_words: got %0d expected 10", cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    build_model(46, 8'h11);
    i_payload_len = 11'd46;
    i_seed = 8'h11;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    n_assert++;
    if (o_tx_data !== exp_d(4)) begin
      n_fail++;
      $display("FAIL mid_word4: got %h expected %h", o_tx_data, exp_d(4));
    end
    i_rst_n = 1'b0;
    #1;
    n_assert++;
    if (o_tx_data !== IDLE_W || o_tx_ctrl !== 8'hFF || {o_frame_valid, o_busy, o_done} !== 3'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h/%h flags=%b expected %h/ff 000", o_tx_data, o_tx_ctrl,
               {o_frame_valid, o_busy, o_done}, IDLE_W);
    end
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    test_frame(46, 8'h5A, 10, 8'hFF);
  endtask

  initial begin
    test_reset();
    test_frame(46, 8'h00, 10, 8'hFF);
    test_pattern();
    test_short_payload();
    test_frame(1500, 8'hC3, 191, 8'hC0);
    test_len_err();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
